fdiv_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision divider, the inverse of the combinational FP multiplier.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fdiv_mant_step.sv | 25 ++
 rtl/fdiv_seq.sv | 127 ++++++++++++
 tb/tb_fdiv_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the FP execute stage.
//   EXP_W / MAN_W / BIAS : IEEE-754 single-precision field geometry
//   QITER                : quotient bits produced by the sequential divider
//   QNAN / PINF          : canned special-result encodings
//   fdiv_state_t         : divider FSM states
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // One quotient bit per DIV cycle. The two extra bits are the
  // integer bit and one guard bit used by normalisation.
  localparam int QITER = MAN_W + 2;
  localparam int CNT_W = $clog2(QITER + 1);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fdiv_state_t;

endpackage

// File: rtl/fdiv_mant_step.sv
// fdiv_mant_step: one combinational restoring-division step.
//   rem_in  [W-1:0] : partial remainder, always < 2*divisor
//   divisor [W-2:0] : normalised mantissa with implicit 1
//   rem_out [W-1:0] : next partial remainder, already shifted left by one
//   qbit            : quotient bit produced by this step
// Kept standalone so a radix-4 variant can chain two of them.
module fdiv_mant_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-2:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         qbit
);

  logic [W-1:0] div_ext;

  assign div_ext = {1'b0, divisor};
  assign qbit    = (rem_in >= div_ext);

  // After a subtract the remainder is below the divisor, so the left
  // shift can never push a set bit out of the W-bit register.
  assign rem_out = qbit ? ((rem_in - div_ext) << 1) : (rem_in << 1);

endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: multi-cycle single-precision divider, FPResult = FPA / FPB.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, only sampled while idle
//   FPA, FPB   : dividend / divisor, captured on the accepting edge
//   busy       : high while a divide is in flight (DIV, NORM)
//   done       : one-cycle pulse, FPResult valid
//   FPResult   : quotient, held until the next done pulse
// Operands are treated as normalised, the quotient is truncated and
// denormal results flush to zero. Latency is fixed at 27 edges from
// the accepting edge to the edge that raises done.
module fdiv_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] FPA,
  input  logic [31:0] FPB,
  output logic        busy,
  output logic        done,
  output logic [31:0] FPResult
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  fdiv_state_t          state, state_nxt;
  logic                 sign;
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic                 a_zero, b_zero;
  logic [MAN_W:0]       man_b;
  logic [QITER-1:0]     rem, quo;
  logic [CNT_W-1:0]     cnt;
  logic [QITER-1:0]     rem_step;
  logic                 qbit;
  logic                 div_last;

  logic signed [9:0]    exp_norm;
  logic [MAN_W-1:0]     man_norm;
  logic [31:0]          result_nxt;

  fdiv_mant_step #(.W(QITER)) u_step (
    .rem_in  (rem),
    .divisor (man_b),
    .rem_out (rem_step),
    .qbit    (qbit)
  );

  // DIV steps while cnt < QITER and spends one more cycle with the full
  // quotient in place before moving on, which sets the fixed latency.
  assign div_last = (cnt == CNT_W'(QITER));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: assign a default first so every path drives state_nxt; a
    // missing branch would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (start)    state_nxt = DIV;
      DIV:  if (div_last) state_nxt = NORM;
      NORM:               state_nxt = DONE;
      DONE:               state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DIV) || (state == NORM);
  assign done = (state == DONE);

  // ----------------------------------------------------------- datapath
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      exp_a    <= '0;
      exp_b    <= '0;
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      man_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      FPResult <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          sign   <= FPA[31] ^ FPB[31];
          exp_a  <= FPA[30:23];
          exp_b  <= FPB[30:23];
          a_zero <= (FPA[30:23] == '0);
          b_zero <= (FPB[30:23] == '0);
          man_b  <= {1'b1, FPB[22:0]};
          rem    <= {1'b0, 1'b1, FPA[22:0]};
          cnt    <= '0;
        end
        DIV: if (!div_last) begin
          rem <= rem_step;
          quo <= {quo[QITER-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        NORM:    FPResult <= result_nxt;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------- normalise and pack
  // The quotient lies in (2^23, 2^25): bit 24 tells whether the mantissa
  // ratio was >= 1, which decides the one-place shift and exponent fix.
  always_comb begin
    exp_norm = signed'({2'b00, exp_a}) - signed'({2'b00, exp_b}) + BIAS_S
             - (quo[QITER-1] ? 10'sd0 : 10'sd1);
    man_norm = quo[QITER-1] ? quo[MAN_W:1] : quo[MAN_W-1:0];

    result_nxt = {sign, exp_norm[EXP_W-1:0], man_norm};
    if (a_zero && b_zero)      result_nxt = QNAN;
    else if (b_zero)           result_nxt = {sign, PINF[30:0]};
    else if (a_zero)           result_nxt = {sign, 31'h0};
    else if (exp_norm >= 10'sd255) result_nxt = {sign, PINF[30:0]};
    else if (exp_norm <= 10'sd0)   result_nxt = {sign, 31'h0};
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed self-checking bench for fdiv_seq.
module tb_fdiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] FPA, FPB;
  logic        busy, done;
  logic [31:0] FPResult;

  int checks   = 0;
  int failures = 0;

  fdiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .FPA      (FPA),
    .FPB      (FPB),
    .busy     (busy),
    .done     (done),
    .FPResult (FPResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp_v);
    end
  endtask

  // Present operands for one edge, then scramble them to show they are
  // captured. Returns after the accepting edge (+1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    FPA   = a;
    FPB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    FPA   = $urandom;
    FPB   = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r);
    int n;
    bit seen;
    issue(a, b);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, n, 32'd27);
    check({tag, "_result"}, FPResult, exp_r);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, FPResult, exp_r);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
    int done_edge;

    vecs[0] = '{"six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{"one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA};
    vecs[2] = '{"neg_q24",     32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000};
    vecs[3] = '{"div_zero",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
    vecs[4] = '{"zero_num",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000};
    vecs[5] = '{"zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000};
    vecs[6] = '{"overflow",    32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000};
    vecs[7] = '{"underflow",   32'h0080_0000, 32'h7F00_0000, 32'h0000_0000};

    rst_n = 1'b0;
    start = 1'b0;
    FPA   = '0;
    FPB   = '0;
    #12;
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", FPResult, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].q);

    // Stray starts during DIV (edge 5), NORM (edge 27) and DONE (edge 28).
    issue(32'h40C0_0000, 32'h4000_0000);
    pulses    = 0;
    done_edge = 0;
    for (int e = 1; e <= 31; e++) begin
      @(negedge clk);
      start = (e == 5) || (e == 27) || (e == 28);
      FPA   = 32'h3F80_0000;
      FPB   = 32'h4040_0000;
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        done_edge = e;
      end
    end
    start = 1'b0;
    check("ignore_pulses",    pulses, 32'd1);
    check("ignore_done_edge", done_edge, 32'd27);
    check("ignore_result",    FPResult, 32'h4040_0000);
    check("ignore_idle",      {31'b0, busy}, 32'd0);

    // Reset in the middle of DIV discards the op and clears the outputs.
    run_op("pre_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'b0, busy}, 32'd0);
    check("midrst_done",   {31'b0, done}, 32'd0);
    check("midrst_result", FPResult, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
